// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the serial configuration flash sequencer.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StData,
    StStall,
    StGap
  } state_e;

  localparam logic [7:0]  OPC_READ       = 8'h03;
  localparam logic [7:0]  OPC_RELEASE_PD = 8'hAB;
  localparam int unsigned HDR_BITS       = 32;

endpackage

// File: rtl/spi_bit_timer.sv
// SPI mode-0 bit clock: SCK_DIV clk cycles low, then SCK_DIV clk cycles high, per bit.
module spi_bit_timer #(
  parameter int unsigned SCK_DIV = 1
) (
  input  logic clk,
  input  logic resetq,
  input  logic run,
  input  logic hold,
  output logic sck,
  output logic fall_tick,
  output logic rise_tick,
  output logic bit_end
);

  localparam int unsigned CntW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sck_q, sck_d;
  logic            active, phase_end;

  assign active    = run & ~hold;
  assign phase_end = (cnt_q == CntW'(SCK_DIV - 1));

  // Stopped or held means parked at the first cycle of a low phase.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!active) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (phase_end) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck       = sck_q;
  // Ticks flag the cycle whose closing edge performs the event.
  assign rise_tick = active & ~sck_q & phase_end;
  assign fall_tick = active & sck_q & phase_end;
  // In mode 0 the bit boundary is the falling edge; kept separate to read by intent.
  assign bit_end   = fall_tick;

endmodule

// File: rtl/spi_flash_ctrl.sv
// Issues a SPI mode-0 READ (opcode + 24-bit address) and streams the returned bytes
// through a one-entry valid/ready register, stalling SCK when the consumer lags.
module spi_flash_ctrl
  import spi_flash_pkg::*;
#(
  parameter int unsigned SCK_DIV = 1,
  parameter int unsigned CS_HIGH = 4,
  parameter logic [7:0]  OPCODE  = OPC_READ
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [15:0] len,
  input  logic        abort,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        done,
  output logic        flash_sck,
  output logic        flash_mosi,
  input  logic        flash_miso,
  output logic        flash_cs_n
);

  localparam int unsigned GapW = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;

  state_e          state_q, state_d;
  logic            cs_n_q, cs_n_d;
  logic [31:0]     tx_sr_q, tx_sr_d;
  logic [7:0]      rx_sr_q, rx_sr_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [15:0]     bytes_q, bytes_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            pending_q, pending_d;
  logic            rd_valid_q, rd_valid_d;
  logic            done_q, done_d;
  logic            active, run, hold, can_load, load, finish;
  logic            sck, fall_tick, rise_tick, bit_end;

  assign active   = state_q inside {StCmd, StAddr, StData, StStall};
  assign run      = active & ~abort;
  assign hold     = (state_q == StStall);
  assign can_load = ~rd_valid_q | rd_ready;

  spi_bit_timer #(
    .SCK_DIV(SCK_DIV)
  ) u_timer (
    .clk      (clk),
    .resetq   (resetq),
    .run      (run),
    .hold     (hold),
    .sck      (sck),
    .fall_tick(fall_tick),
    .rise_tick(rise_tick),
    .bit_end  (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    cs_n_d     = cs_n_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rd_data_d  = rd_data_q;
    bit_cnt_d  = bit_cnt_q;
    bytes_d    = bytes_q;
    gap_d      = gap_q;
    pending_d  = pending_q;
    rd_valid_d = rd_valid_q & ~rd_ready;
    done_d     = 1'b0;
    load       = 1'b0;
    finish     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && len == '0) begin
          done_d = 1'b1;
        end else if (start) begin
          state_d   = StCmd;
          cs_n_d    = 1'b0;
          tx_sr_d   = {OPCODE, addr};
          bytes_d   = len;
          bit_cnt_d = '0;
          pending_d = 1'b0;
        end
      end
      StCmd, StAddr: begin
        if (fall_tick) tx_sr_d = {tx_sr_q[30:0], 1'b0};
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) state_d = StAddr;
          if (bit_cnt_q == 5'(HDR_BITS - 1)) state_d = StData;
        end
      end
      StData: begin
        if (rise_tick) begin
          rx_sr_d = {rx_sr_q[6:0], flash_miso};
          if (bit_cnt_q[2:0] == 3'd7) pending_d = 1'b1;
        end
        if (pending_q && can_load) load = 1'b1;
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q[2:0] == 3'd7) begin
            bytes_d = bytes_q - 16'd1;
            if (pending_q && !can_load) begin
              state_d = StStall;
            end else if (bytes_q == 16'd1) begin
              finish = 1'b1;
            end
          end
        end
      end
      StStall: begin
        if (can_load) begin
          load = 1'b1;
          if (bytes_q == '0) finish = 1'b1;
          else               state_d = StData;
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - GapW'(1);
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      rd_data_d  = rx_sr_q;
      rd_valid_d = 1'b1;
      pending_d  = 1'b0;
    end

    if (finish) begin
      state_d = StGap;
      cs_n_d  = 1'b1;
      done_d  = 1'b1;
      gap_d   = GapW'(CS_HIGH - 1);
    end

    // Abort drops any partial or buffered byte and still honours the CS gap.
    if (abort && active) begin
      state_d    = StGap;
      cs_n_d     = 1'b1;
      tx_sr_d    = '0;
      rd_valid_d = 1'b0;
      pending_d  = 1'b0;
      done_d     = 1'b0;
      gap_d      = GapW'(CS_HIGH - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      state_q    <= StIdle;
      cs_n_q     <= 1'b1;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rd_data_q  <= '0;
      bit_cnt_q  <= '0;
      bytes_q    <= '0;
      gap_q      <= '0;
      pending_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cs_n_q     <= cs_n_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rd_data_q  <= rd_data_d;
      bit_cnt_q  <= bit_cnt_d;
      bytes_q    <= bytes_d;
      gap_q      <= gap_d;
      pending_q  <= pending_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign flash_sck  = sck;
  assign flash_mosi = tx_sr_q[31];
  assign flash_cs_n = cs_n_q;

endmodule
